usb_pkt_serializer: RTL and testbench

//  Parametrised successor to the fixed-format packet encoder: serialises SYNC + variable-length

---
 rtl/usb_pkt_serializer_pkg.sv | 50 +++++
 rtl/usb_pkt_serializer_crc.sv | 44 ++++
 rtl/usb_pkt_serializer.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_pkt_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_serializer_pkg.sv
// Shared types and constants for the USB packet serializer: FSM states, CRC modes,
// CRC polynomials/residues and common PID values.
package usb_pkt_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SYNC,
    ST_BODY,
    ST_CRC,
    ST_EOPW
  } state_e;

  typedef enum logic [1:0] {
    CRC_NONE = 2'b00,
    CRC_5    = 2'b01,
    CRC_16   = 2'b10
  } crc_mode_e;

  localparam logic [7:0]  SYNC_DEFAULT  = 8'h80;

  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_INIT     = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  localparam logic [7:0]  PID_OUT   = 8'hE1;
  localparam logic [7:0]  PID_IN    = 8'h69;
  localparam logic [7:0]  PID_SOF   = 8'hA5;
  localparam logic [7:0]  PID_SETUP = 8'h2D;
  localparam logic [7:0]  PID_DATA0 = 8'hC3;
  localparam logic [7:0]  PID_DATA1 = 8'h4B;
  localparam logic [7:0]  PID_ACK   = 8'hD2;
  localparam logic [7:0]  PID_NAK   = 8'h5A;
  localparam logic [7:0]  PID_STALL = 8'h1E;

  // The reserved encoding 2'b11 behaves as "no CRC".
  function automatic crc_mode_e decode_crc_mode(input logic [1:0] sel);
    crc_mode_e m;
    case (sel)
      2'b01:   m = CRC_5;
      2'b10:   m = CRC_16;
      default: m = CRC_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/usb_pkt_serializer_crc.sv
// Bit-serial CRC engine (MSB-feedback shift register). crc_o already includes the bit
// presented this cycle when en_i is high, so the caller can load the final value on the last edge.
module usb_pkt_serializer_crc
  import usb_pkt_serializer_pkg::*;
#(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = CRC16_POLY,
  parameter logic [W-1:0]   INIT = CRC16_INIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] crc_o
);

  logic [W-1:0] crc_q;
  logic [W-1:0] crc_d;
  logic [W-1:0] step;
  logic         fb;

  always_comb begin
    fb    = din_i ^ crc_q[W-1];
    step  = {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = INIT;
    end else if (en_i) begin
      crc_d = step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = en_i ? step : crc_q;

endmodule

// File: rtl/usb_pkt_serializer.sv
// USB packet serializer: SYNC, variable-length body (PID first) and optional inverted
// CRC5/CRC16, LSB-first per field, handed one bit at a time to the bit stuffer.
module usb_pkt_serializer
  import usb_pkt_serializer_pkg::*;
#(
  parameter int         MAX_BITS = 88,
  parameter int         LEN_W    = $clog2(MAX_BITS + 1),
  parameter logic [7:0] SYNC_PAT = SYNC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  input  logic [MAX_BITS-1:0] pkt_data,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic [1:0]          pkt_crc,
  input  logic                abort,
  input  logic                pause,
  output logic                start,
  output logic                endr,
  output logic                s_out,
  output logic                s_valid,
  input  logic                sent_pkt,
  output logic                pkt_done,
  output logic                busy
);

  // Counter must also reach 15 while shifting out CRC16.
  localparam int CNT_W = ($clog2(MAX_BITS) < 4) ? 4 : $clog2(MAX_BITS);

  state_e              state_q;
  crc_mode_e           mode_q;
  logic [MAX_BITS-1:0] data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    last_q;
  logic [CNT_W-1:0]    crc_last;
  logic [15:0]         sh_q;
  logic [15:0]         sh_load;
  logic                pkt_ready_q;
  logic                start_q;
  logic                endr_q;
  logic                s_out_q;
  logic                s_valid_q;
  logic                pkt_done_q;

  logic                crc_en;
  logic                crc_clr;
  logic                crc_din;
  logic [4:0]          crc5_w;
  logic [15:0]         crc16_w;

  // Illegal lengths round down to a byte multiple, clamp to MAX_BITS, floor at one byte.
  function automatic logic [CNT_W-1:0] last_index(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] l;
    if (len > LEN_W'(MAX_BITS)) begin
      l = LEN_W'(MAX_BITS);
    end else begin
      l = {len[LEN_W-1:3], 3'b000};
    end
    if (l < LEN_W'(8)) begin
      l = LEN_W'(8);
    end
    return CNT_W'(l - LEN_W'(1));
  endfunction

  assign cnt_d    = cnt_q + CNT_W'(1);
  assign crc_last = (mode_q == CRC_5) ? CNT_W'(4) : CNT_W'(15);

  // The PID byte is excluded from CRC coverage.
  assign crc_en  = (state_q == ST_BODY) && !pause && !abort && (cnt_q >= CNT_W'(8));
  assign crc_clr = (state_q == ST_START);
  assign crc_din = data_q[cnt_q];

  // CRC5 is left-aligned so the shifter always emits from bit 15.
  assign sh_load = (mode_q == CRC_5) ? {~crc5_w, 11'b0} : ~crc16_w;

  usb_pkt_serializer_crc #(
    .W    (5),
    .POLY (CRC5_POLY),
    .INIT (CRC5_INIT)
  ) u_crc5 (
    .clk   (clk),
    .rst   (rst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .din_i (crc_din),
    .crc_o (crc5_w)
  );

  usb_pkt_serializer_crc #(
    .W    (16),
    .POLY (CRC16_POLY),
    .INIT (CRC16_INIT)
  ) u_crc16 (
    .clk   (clk),
    .rst   (rst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .din_i (crc_din),
    .crc_o (crc16_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= CRC_NONE;
      data_q      <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      sh_q        <= '0;
      pkt_ready_q <= 1'b1;
      start_q     <= 1'b0;
      endr_q      <= 1'b0;
      s_out_q     <= 1'b0;
      s_valid_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      pkt_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pkt_valid && pkt_ready_q) begin
            data_q      <= pkt_data;
            last_q      <= last_index(pkt_len);
            mode_q      <= decode_crc_mode(pkt_crc);
            pkt_ready_q <= 1'b0;
            start_q     <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          if (abort) begin
            endr_q  <= 1'b1;
            state_q <= ST_EOPW;
          end else begin
            cnt_q     <= '0;
            s_valid_q <= 1'b1;
            s_out_q   <= SYNC_PAT[0];
            state_q   <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (abort) begin
            s_valid_q <= 1'b0;
            s_out_q   <= 1'b0;
            endr_q    <= 1'b1;
            state_q   <= ST_EOPW;
          end else if (!pause) begin
            if (cnt_q == CNT_W'(7)) begin
              cnt_q   <= '0;
              s_out_q <= data_q[0];
              state_q <= ST_BODY;
            end else begin
              cnt_q   <= cnt_d;
              s_out_q <= SYNC_PAT[cnt_d[2:0]];
            end
          end
        end
        ST_BODY: begin
          if (abort) begin
            s_valid_q <= 1'b0;
            s_out_q   <= 1'b0;
            endr_q    <= 1'b1;
            state_q   <= ST_EOPW;
          end else if (!pause) begin
            if (cnt_q == last_q) begin
              if (mode_q == CRC_NONE) begin
                s_valid_q <= 1'b0;
                s_out_q   <= 1'b0;
                endr_q    <= 1'b1;
                state_q   <= ST_EOPW;
              end else begin
                cnt_q   <= '0;
                sh_q    <= sh_load;
                s_out_q <= sh_load[15];
                state_q <= ST_CRC;
              end
            end else begin
              cnt_q   <= cnt_d;
              s_out_q <= data_q[cnt_d];
            end
          end
        end
        ST_CRC: begin
          if (abort || (!pause && cnt_q == crc_last)) begin
            s_valid_q <= 1'b0;
            s_out_q   <= 1'b0;
            endr_q    <= 1'b1;
            state_q   <= ST_EOPW;
          end else if (!pause) begin
            cnt_q   <= cnt_d;
            sh_q    <= {sh_q[14:0], 1'b0};
            s_out_q <= sh_q[14];
          end
        end
        ST_EOPW: begin
          // A packet offered alongside sent_pkt waits until the IDLE cycle that follows.
          if (sent_pkt) begin
            endr_q      <= 1'b0;
            pkt_done_q  <= 1'b1;
            pkt_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pkt_ready = pkt_ready_q;
  assign start     = start_q;
  assign endr      = endr_q;
  assign s_out     = s_out_q;
  assign s_valid   = s_valid_q;
  assign pkt_done  = pkt_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Scoreboard bench for usb_pkt_serializer: the driver queues hand-derived wire bits,
// a negedge monitor pops and compares every bit the stuffer would consume.
module tb_usb_pkt_serializer;

  localparam int MAX_BITS = 88;
  localparam int LEN_W    = 7;

  logic                clk = 1'b0;
  logic                rst;
  logic                pkt_valid;
  logic                pkt_ready;
  logic [MAX_BITS-1:0] pkt_data;
  logic [LEN_W-1:0]    pkt_len;
  logic [1:0]          pkt_crc;
  logic                abort;
  logic                pause;
  logic                start;
  logic                endr;
  logic                s_out;
  logic                s_valid;
  logic                sent_pkt;
  logic                pkt_done;
  logic                busy;

  int   errors = 0;
  int   checks = 0;
  int   bits_seen = 0;
  logic exp_q[$];
  logic hold_prev = 1'b0;
  logic out_prev  = 1'b0;

  always #5 clk = ~clk;

  usb_pkt_serializer #(
    .MAX_BITS (MAX_BITS),
    .LEN_W    (LEN_W),
    .SYNC_PAT (8'h80)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .pkt_len   (pkt_len),
    .pkt_crc   (pkt_crc),
    .abort     (abort),
    .pause     (pause),
    .start     (start),
    .endr      (endr),
    .s_out     (s_out),
    .s_valid   (s_valid),
    .sent_pkt  (sent_pkt),
    .pkt_done  (pkt_done),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bits are written left-to-right in wire order: v[n-1] goes out first.
  task automatic push_vec(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
  endtask

  // Monitor: a bit counts as consumed when shown with pause low (and not overridden).
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk($sformatf("hold_bit%0d", bits_seen), {30'd0, s_valid, s_out}, {30'd0, 1'b1, out_prev});
      end
      if (s_valid && !pause && !abort) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("extra_bit%0d", bits_seen), {31'd0, s_valid}, 32'd0);
        end else begin
          logic e;
          e = exp_q.pop_front();
          chk($sformatf("bit%0d", bits_seen), {31'd0, s_out}, {31'd0, e});
        end
        bits_seen++;
      end
      hold_prev = s_valid && pause && !abort;
      out_prev  = s_out;
    end
  end

  task automatic run_pkt(input string nm, input logic [MAX_BITS-1:0] d, input logic [LEN_W-1:0] len,
                         input logic [1:0] crc, input int pmode, input int abort_at,
                         input int rst_at, input int nexp, input bit simul);
    int cyc;
    bits_seen = 0;
    pkt_data  = d;
    pkt_len   = len;
    pkt_crc   = crc;
    pkt_valid = 1'b1;
    chk({nm, "_ready_idle"}, {31'd0, pkt_ready}, 32'd1);
    tick();
    pkt_valid = 1'b0;
    chk({nm, "_start"}, {31'd0, start}, 32'd1);
    chk({nm, "_ready_busy"}, {31'd0, pkt_ready}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    tick();
    chk({nm, "_start_pulse"}, {31'd0, start}, 32'd0);
    cyc = 0;
    while (!endr && cyc < 600) begin
      pause = (pmode == 1) && (cyc % 3 == 2);
      if (abort_at >= 0 && bits_seen == abort_at) abort = 1'b1;
      if (rst_at >= 0 && bits_seen == rst_at) begin
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        pause = 1'b0;
        chk({nm, "_rst_svalid"}, {31'd0, s_valid}, 32'd0);
        chk({nm, "_rst_start"}, {31'd0, start}, 32'd0);
        chk({nm, "_rst_endr"}, {31'd0, endr}, 32'd0);
        chk({nm, "_rst_done"}, {31'd0, pkt_done}, 32'd0);
        chk({nm, "_rst_ready"}, {31'd0, pkt_ready}, 32'd1);
        chk({nm, "_rst_busy"}, {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk({nm, "_rst_no_endr"}, {30'd0, endr, pkt_done}, 32'd0);
        chk({nm, "_bits"}, bits_seen, nexp);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
        return;
      end
      tick();
      abort = 1'b0;
      cyc++;
    end
    pause = 1'b0;
    chk({nm, "_endr"}, {31'd0, endr}, 32'd1);
    chk({nm, "_svalid_eop"}, {31'd0, s_valid}, 32'd0);
    pause = 1'b1;
    tick();
    chk({nm, "_endr_held"}, {31'd0, endr}, 32'd1);
    chk({nm, "_done_early"}, {31'd0, pkt_done}, 32'd0);
    pause = 1'b0;
    tick();
    sent_pkt  = 1'b1;
    pkt_valid = simul;
    tick();
    sent_pkt  = 1'b0;
    pkt_valid = 1'b0;
    chk({nm, "_done"}, {31'd0, pkt_done}, 32'd1);
    chk({nm, "_ready_after"}, {31'd0, pkt_ready}, 32'd1);
    chk({nm, "_endr_clear"}, {31'd0, endr}, 32'd0);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
    chk({nm, "_done_pulse"}, {31'd0, pkt_done}, 32'd0);
    chk({nm, "_no_restart"}, {30'd0, start, busy}, 32'd0);
    chk({nm, "_bits"}, bits_seen, nexp);
    chk({nm, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pkt_valid = 1'b0;
    pkt_data  = '0;
    pkt_len   = '0;
    pkt_crc   = 2'b00;
    abort     = 1'b0;
    pause     = 1'b0;
    sent_pkt  = 1'b0;
    tick();
    tick();
    chk("reset_ready", {31'd0, pkt_ready}, 32'd1);
    chk("reset_outs", {26'd0, start, endr, s_out, s_valid, pkt_done, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // ACK, with a packet offered together with sent_pkt
    push_vec(8'b00000001, 8); push_vec(8'b01001011, 8);
    run_pkt("ack", 88'hD2, 7'd8, 2'b00, 0, -1, -1, 16, 1'b1);

    // ACK with pause every third cycle
    push_vec(8'b00000001, 8); push_vec(8'b01001011, 8);
    run_pkt("ack_pause", 88'hD2, 7'd8, 2'b00, 1, -1, -1, 16, 1'b0);

    // IN token, CRC5 over one zero byte: ~CRC = 5'b10000
    push_vec(8'b00000001, 8); push_vec(8'b10010110, 8); push_zeros(8); push_vec(5'b10000, 5);
    run_pkt("in_crc5", 88'h0069, 7'd16, 2'b01, 0, -1, -1, 29, 1'b0);

    // DATA0 empty: CRC16 untouched, inverted init is zero
    push_vec(8'b00000001, 8); push_vec(8'b11000011, 8); push_zeros(16);
    run_pkt("data0_empty", 88'hC3, 7'd8, 2'b10, 0, -1, -1, 32, 1'b0);

    // DATA0 with one 0x00 byte: CRC16 = 16'hFD02, inverted 16'h02FD
    push_vec(8'b00000001, 8); push_vec(8'b11000011, 8); push_zeros(8);
    push_vec(16'b0000_0010_1111_1101, 16);
    run_pkt("data0_byte", 88'h00C3, 7'd16, 2'b10, 1, -1, -1, 40, 1'b0);

    // len 13 rounds down to 8, reserved CRC code means none
    push_vec(8'b00000001, 8); push_vec(8'b01001011, 8);
    run_pkt("len13", 88'hFFD2, 7'd13, 2'b11, 0, -1, -1, 16, 1'b0);

    // len 0 clamps up to 8
    push_vec(8'b00000001, 8); push_vec(8'b01001011, 8);
    run_pkt("len0", 88'hD2, 7'd0, 2'b00, 0, -1, -1, 16, 1'b0);

    // len 100 clamps to MAX_BITS
    push_vec(8'b00000001, 8); push_vec(8'b01001011, 8); push_zeros(80);
    run_pkt("len100", 88'hD2, 7'd100, 2'b00, 0, -1, -1, 96, 1'b0);

    // abort after 10 bits of an 88-bit DATA1 packet
    push_vec(8'b00000001, 8); push_vec(2'b11, 2);
    run_pkt("abort", {80'h0123_4567_89AB_CDEF_5A5A, 8'h4B}, 7'd88, 2'b10, 0, 10, -1, 10, 1'b0);

    // reset after 20 bits, mid-body
    push_vec(8'b00000001, 8); push_vec(8'b11000011, 8); push_vec(4'b0011, 4);
    run_pkt("rst_mid", {72'hAB_CDEF_0123_4567_89AB, 16'h3CC3}, 7'd88, 2'b10, 0, -1, 20, 20, 1'b0);

    // ACK after the mid-packet reset
    push_vec(8'b00000001, 8); push_vec(8'b01001011, 8);
    run_pkt("ack_after_rst", 88'hD2, 7'd8, 2'b00, 0, -1, -1, 16, 1'b0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
